// File: rtl/alu4_seq_pkg.sv
// Shared definitions for the alu4_seq nibble-serial ALU sequencer.
// Optional feature macro: ALU4_SEQ_EQ_EARLY_EN (early exit for the equality op).
package alu4_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry-in for nibble 0, indexed by op: subtract-style ops start with 1.
  localparam logic [7:0] CIN_INIT = 8'b1100_0010;

  // Ops whose carry/overflow flags are meaningful.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT) || (op == OP_EQ);
  endfunction

endpackage

// File: rtl/alu4_seq_shreg.sv
// Nibble shift register: parallel load, shift right by one nibble, exposes low nibble.
module alu4_seq_shreg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  output logic [3:0]   low
);

  logic [W-1:0] data_q;

  // Load has priority; shifting brings the next nibble into the low position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_val;
    end else if (shift) begin
      data_q <= {4'h0, data_q[W-1:4]};
    end
  end

  assign low = data_q[3:0];

endmodule

// File: rtl/alu4_seq.sv
// Multi-cycle sequencer driving an external 4-bit ALU, one nibble per cycle, LSB first.
// Optional feature macro: ALU4_SEQ_EQ_EARLY_EN -- the equality op finishes on the
// first nibble that differs instead of always running NIBBLES cycles.
module alu4_seq
  import alu4_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W      = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_result,
  output logic         resp_carry,
  output logic         resp_overflow,
  output logic         resp_zero,
  output logic         resp_size,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [2:0]   alu_c,
  output logic         alu_cin,
  input  logic [3:0]   alu_result,
  input  logic         alu_carry,
  input  logic         alu_overflow
);

  localparam int unsigned CntW = $clog2(NIBBLES);

  state_t          state_q;
  logic [2:0]      op_q;
  logic [CntW-1:0] count_q;
  logic            carry_q;
  logic            zero_acc_q;
  logic [W-1:0]    result_q;
  logic            carry_out_q;
  logic            ovf_out_q;
  logic            zero_out_q;
  logic            size_out_q;

  logic            accept;
  logic            running;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic            early;
  logic            last;
  logic            zero_fin;
  logic            size_fin;

  assign accept  = (state_q == IDLE) && req_valid;
  assign running = (state_q == RUN);

  alu4_seq_shreg #(
    .W (W)
  ) u_shreg_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (req_a),
    .shift    (running),
    .low      (a_nib)
  );

  alu4_seq_shreg #(
    .W (W)
  ) u_shreg_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (req_b),
    .shift    (running),
    .low      (b_nib)
  );

`ifdef ALU4_SEQ_EQ_EARLY_EN
  // Any nonzero difference nibble already decides inequality.
  assign early = (op_q == OP_EQ) && (alu_result != 4'h0);
`else
  assign early = 1'b0;
`endif

  assign last = (count_q == CntW'(NIBBLES - 1)) || early;

  // Final zero/size flags, evaluated on the closing nibble.
  always_comb begin
    zero_fin = zero_acc_q && (alu_result == 4'h0);
    size_fin = 1'b0;
    unique case (op_q)
      OP_SLT:  size_fin = alu_result[3] ^ alu_overflow;
      OP_EQ:   size_fin = zero_fin;
      default: size_fin = 1'b0;
    endcase
  end

  // ALU drive is forced to zero outside RUN so the shared ALU sees a quiet input.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_c   = '0;
    alu_cin = 1'b0;
    if (running) begin
      alu_a   = a_nib;
      alu_b   = b_nib;
      alu_c   = op_q;
      alu_cin = (count_q == '0) ? CIN_INIT[op_q] : carry_q;
    end
  end

  // Sequencer FSM with registered response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      count_q     <= '0;
      carry_q     <= 1'b0;
      zero_acc_q  <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      ovf_out_q   <= 1'b0;
      zero_out_q  <= 1'b0;
      size_out_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            result_q   <= '0;
            zero_acc_q <= 1'b1;
            count_q    <= '0;
            carry_q    <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // Nibble k lands in bits [4k+3:4k]; unwritten upper nibbles stay zero.
          result_q[{count_q, 2'b00} +: 4] <= alu_result;
          carry_q    <= alu_carry;
          zero_acc_q <= zero_fin;
          count_q    <= count_q + CntW'(1);
          if (last) begin
            carry_out_q <= is_arith(op_q) ? alu_carry : 1'b0;
            ovf_out_q   <= is_arith(op_q) ? alu_overflow : 1'b0;
            zero_out_q  <= zero_fin;
            size_out_q  <= size_fin;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == DONE);
  assign resp_result   = result_q;
  assign resp_carry    = carry_out_q;
  assign resp_overflow = ovf_out_q;
  assign resp_zero     = zero_out_q;
  assign resp_size     = size_out_q;

endmodule

// File: tb/tb_alu4_seq.sv
// Self-checking bench for alu4_seq: behavioural ALU4 environment plus a word-level
// reference model of each operation.
module tb_alu4_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    logic         s;
    logic [7:0]   lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_result;
  logic         resp_carry, resp_overflow, resp_zero, resp_size;
  logic [3:0]   alu_a, alu_b, alu_result;
  logic [2:0]   alu_c;
  logic         alu_cin, alu_carry, alu_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu4_seq #(
    .NIBBLES (NIBBLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_carry    (resp_carry),
    .resp_overflow (resp_overflow),
    .resp_zero     (resp_zero),
    .resp_size     (resp_size),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_c         (alu_c),
    .alu_cin       (alu_cin),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .alu_overflow  (alu_overflow)
  );

  // Parent's combinational 4-bit ALU: subtract-style ops add the inverted b.
  logic [3:0] alu_bb;
  logic [4:0] alu_sum;
  logic       alu_arith;
  always_comb begin
    alu_arith = (alu_c == 3'd0) || (alu_c == 3'd1) || (alu_c == 3'd6) || (alu_c == 3'd7);
    alu_bb    = (alu_c == 3'd0) ? alu_b : ~alu_b;
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_bb} + {4'b0, alu_cin};
    case (alu_c)
      3'd2:    alu_result = ~alu_a;
      3'd3:    alu_result = alu_a & alu_b;
      3'd4:    alu_result = alu_a | alu_b;
      3'd5:    alu_result = alu_a ^ alu_b;
      default: alu_result = alu_sum[3:0];
    endcase
    alu_carry    = alu_arith ? alu_sum[4] : 1'b0;
    alu_overflow = alu_arith ? ((alu_a[3] == alu_bb[3]) && (alu_sum[3] != alu_a[3])) : 1'b0;
  end

  // Word-level reference of the whole operation.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b);
    exp_t e;
    logic [W:0] full;
    logic [3:0] an, bn, dn;
    logic       found;
    e     = '0;
    e.lat = 8'(NIBBLES);
    case (op)
      3'd0: begin
        full = {1'b0, a} + {1'b0, b};
        e.r  = full[W-1:0];
        e.c  = full[W];
        e.v  = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'd1, 3'd6, 3'd7: begin
        e.r = a - b;
        e.c = (a >= b);
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      3'd2: e.r = ~a;
      3'd3: e.r = a & b;
      3'd4: e.r = a | b;
      default: e.r = a ^ b;
    endcase
    e.z = (e.r == '0);
    if (op == 3'd6) e.s = ($signed(a) < $signed(b));
    if (op == 3'd7) e.s = (a == b);
    found = 1'b0;
`ifdef ALU4_SEQ_EQ_EARLY_EN
    if (op == 3'd7) begin
      for (int k = 0; k < int'(NIBBLES); k++) begin
        an = a[4*k +: 4];
        bn = b[4*k +: 4];
        if (!found && an != bn) begin
          found = 1'b1;
          dn    = an - bn;
          e.lat = 8'(k + 1);
          e.r   = (a - b) & ({W{1'b1}} >> (W - 4 * (k + 1)));
          e.c   = (an >= bn);
          e.v   = (an[3] != bn[3]) && (dn[3] != an[3]);
          e.z   = 1'b0;
          e.s   = 1'b0;
        end
      end
    end
`else
    an = '0;
    bn = '0;
    dn = '0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input exp_t e);
    check({tag, ".result"}, 32'(resp_result), 32'(e.r));
    check({tag, ".carry"}, 32'(resp_carry), 32'(e.c));
    check({tag, ".overflow"}, 32'(resp_overflow), 32'(e.v));
    check({tag, ".zero"}, 32'(resp_zero), 32'(e.z));
    check({tag, ".size"}, 32'(resp_size), 32'(e.s));
  endtask

  // One full transaction; stray req_valid is driven during RUN/DONE to show it is ignored.
  task automatic run_txn(input string tag, input logic [2:0] op, input logic [W-1:0] a, b,
                         input int hold);
    exp_t e;
    int   n;
    e = model(op, a, b);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    req_op = 3'($urandom);
    req_a  = W'($urandom);
    req_b  = W'($urandom);
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    check({tag, ".latency"}, 32'(n), 32'(e.lat));
    check_resp(tag, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      check_resp({tag, ".hold"}, e);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    #3;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.result", 32'(resp_result), 32'd0);
    check("rst.flags", {28'd0, resp_carry, resp_overflow, resp_zero, resp_size}, 32'd0);
    check("rst.alu", {20'd0, alu_a, alu_b, alu_c, alu_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("add1", 3'd0, 16'h1234, 16'h0FFF, 0);
    run_txn("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 0);
    run_txn("sub_borrow", 3'd1, 16'h0000, 16'h0001, 0);
    run_txn("slt_ovf", 3'd6, 16'h8000, 16'h0001, 0);
    run_txn("slt_gt", 3'd6, 16'h0005, 16'h0003, 0);
    run_txn("eq_same", 3'd7, 16'hABCD, 16'hABCD, 0);
    run_txn("eq_diff", 3'd7, 16'hABCD, 16'hABCE, 0);
    run_txn("xor", 3'd5, 16'hF0F0, 16'hFF00, 0);
    run_txn("not", 3'd2, 16'h1234, 16'h5555, 0);
    run_txn("and_zero", 3'd3, 16'hF0F0, 16'h0F0F, 0);
    run_txn("or", 3'd4, 16'h1200, 16'h0034, 0);
    run_txn("hold3", 3'd0, 16'hFFFF, 16'h0001, 3);

    // Reset pulse in the middle of RUN: no response, then normal operation.
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 16'h1111;
    req_b     = 16'h2222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst.req_ready", 32'(req_ready), 32'd1);
    check("midrst.resp_valid", 32'(resp_valid), 32'd0);
    check("midrst.alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < int'(NIBBLES) + 3; i++) begin
      @(posedge clk); #1;
      seen = seen | resp_valid;
    end
    check("midrst.no_resp", 32'(seen), 32'd0);
    run_txn("after_rst", 3'd1, 16'h5000, 16'h1234, 0);

    // Randomized operations; equality sometimes gets matching or near-matching operands.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(7, 0));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (rop == 3'd7 && ($urandom_range(1, 0) == 1)) begin
        rb = ra ^ (W'($urandom_range(1, 0)) << (4 * $urandom_range(NIBBLES - 1, 0)));
      end
      run_txn("rand", rop, ra, rb, int'($urandom_range(2, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
